// File: rtl/lcd_frame_reader_if.sv
// Pixel-path bundle between lcd_frame_reader (master), the SDRAM read-port FIFO and the LCD panel.
interface lcd_frame_reader_if #(
    parameter int unsigned DATA_W = 16
);
    logic              sdram_init_done;
    logic [DATA_W-1:0] rd_data;
    logic              rd_en;
    logic              rd_load;
    logic              sdram_read_valid;
    logic              lcd_hs;
    logic              lcd_vs;
    logic              lcd_de;
    logic [DATA_W-1:0] lcd_data;
    logic [7:0]        frame_cnt;

    modport master (
        input  sdram_init_done,
        input  rd_data,
        output rd_en,
        output rd_load,
        output sdram_read_valid,
        output lcd_hs,
        output lcd_vs,
        output lcd_de,
        output lcd_data,
        output frame_cnt
    );

    modport slave (
        output sdram_init_done,
        output rd_data,
        input  rd_en,
        input  rd_load,
        input  sdram_read_valid,
        input  lcd_hs,
        input  lcd_vs,
        input  lcd_de,
        input  lcd_data,
        input  frame_cnt
    );
endinterface

// File: rtl/lcd_frame_reader.sv
// LCD timing generator streaming pixels from the SDRAM read FIFO.
// Define LCD_TEST_PATTERN_EN to replace FIFO pixels with 8 vertical colour bars.
module lcd_frame_reader #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned H_SYNC  = 128,
    parameter int unsigned H_BACK  = 88,
    parameter int unsigned H_DISP  = 800,
    parameter int unsigned H_FRONT = 40,
    parameter int unsigned V_SYNC  = 2,
    parameter int unsigned V_BACK  = 33,
    parameter int unsigned V_DISP  = 480,
    parameter int unsigned V_FRONT = 10
) (
    input  logic clk,
    input  logic rst,
    lcd_frame_reader_if.master bus
);

    localparam int unsigned H_TOTAL     = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int unsigned V_TOTAL     = V_SYNC + V_BACK + V_DISP + V_FRONT;
    localparam int unsigned H_W         = $clog2(H_TOTAL);
    localparam int unsigned V_W         = $clog2(V_TOTAL);
    localparam int unsigned H_ACT_START = H_SYNC + H_BACK;
    localparam int unsigned H_ACT_END   = H_ACT_START + H_DISP;
    localparam int unsigned V_ACT_START = V_SYNC + V_BACK;
    localparam int unsigned V_ACT_END   = V_ACT_START + V_DISP;

    typedef enum logic {
        WAIT_INIT = 1'b0,
        RUN       = 1'b1
    } state_t;

    state_t            state_q;
    logic [H_W-1:0]    h_cnt_q, h_cnt_d;
    logic [V_W-1:0]    v_cnt_q, v_cnt_d;
    logic [7:0]        frame_cnt_q, frame_cnt_d;
    logic              rd_load_q;
    logic              lcd_hs_q;
    logic              lcd_vs_q;
    logic              lcd_de_q;

    logic [31:0]       h_pos;
    logic [31:0]       v_pos;
    logic              run;
    logic              h_last;
    logic              v_last;
    logic              in_hsync;
    logic              in_vsync;
    logic              h_active;
    logic              v_active;
    logic              active;

    assign h_pos    = 32'(h_cnt_q);
    assign v_pos    = 32'(v_cnt_q);
    assign run      = (state_q == RUN);
    assign h_last   = (h_pos == H_TOTAL - 1);
    assign v_last   = (v_pos == V_TOTAL - 1);
    assign in_hsync = (h_pos < H_SYNC);
    assign in_vsync = (v_pos < V_SYNC);
    assign h_active = (h_pos >= H_ACT_START) && (h_pos < H_ACT_END);
    assign v_active = (v_pos >= V_ACT_START) && (v_pos < V_ACT_END);
    assign active   = run && h_active && v_active;

    // Counters only advance in RUN, so the first frame starts cleanly at 0/0.
    always_comb begin
        h_cnt_d     = h_cnt_q;
        v_cnt_d     = v_cnt_q;
        frame_cnt_d = frame_cnt_q;
        if (run) begin
            if (h_last) begin
                h_cnt_d = '0;
                if (v_last) begin
                    v_cnt_d     = '0;
                    frame_cnt_d = frame_cnt_q + 8'd1;
                end else begin
                    v_cnt_d = v_cnt_q + 1'b1;
                end
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= WAIT_INIT;
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            frame_cnt_q <= '0;
            rd_load_q   <= 1'b0;
            lcd_hs_q    <= 1'b1;
            lcd_vs_q    <= 1'b1;
            lcd_de_q    <= 1'b0;
        end else begin
            case (state_q)
                WAIT_INIT: state_q <= bus.sdram_init_done ? RUN : WAIT_INIT;
                RUN:       state_q <= RUN;
                default:   state_q <= WAIT_INIT;
            endcase
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            rd_load_q   <= run && in_vsync;
            lcd_hs_q    <= !(run && in_hsync);
            lcd_vs_q    <= !(run && in_vsync);
            lcd_de_q    <= active;
        end
    end

    assign bus.rd_load   = rd_load_q;
    assign bus.lcd_hs    = lcd_hs_q;
    assign bus.lcd_vs    = lcd_vs_q;
    assign bus.lcd_de    = lcd_de_q;
    assign bus.frame_cnt = frame_cnt_q;

`ifdef LCD_TEST_PATTERN_EN
    localparam logic [H_W-1:0] H_ACT_START_C = H_ACT_START[H_W-1:0];
    localparam logic [H_W+2:0] H_DISP_C      = H_DISP[H_W+2:0];

    logic [H_W+2:0]    h_off_x8;
    logic [H_W+2:0]    bar_idx;
    logic              pat_bit;
    logic [DATA_W-1:0] pat_word;
    logic [DATA_W-1:0] lcd_data_q;
    logic              unused_bits;

    // Bar index = offset*8/H_DISP; odd bars are all-ones, even bars all-zeros.
    assign h_off_x8    = {h_cnt_q - H_ACT_START_C, 3'b000};
    assign bar_idx     = h_off_x8 / H_DISP_C;
    assign pat_bit     = bar_idx[0];
    assign unused_bits = ^{bar_idx[H_W+2:1], bus.rd_data};

    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_pat
        assign pat_word[gi] = pat_bit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lcd_data_q <= '0;
        end else begin
            lcd_data_q <= active ? pat_word : '0;
        end
    end

    assign bus.rd_en            = 1'b0;
    assign bus.sdram_read_valid = 1'b0;
    assign bus.lcd_data         = lcd_data_q;
`else
    logic              read_valid_q;
    logic [DATA_W-1:0] pix_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            read_valid_q <= 1'b0;
        end else begin
            read_valid_q <= run && !in_vsync;
        end
    end

    // rd_data is already the FIFO's registered output one clk after rd_en,
    // so gating it with the delayed data enable keeps pixel and DE aligned.
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_pix
        assign pix_data[gi] = lcd_de_q & bus.rd_data[gi];
    end

    assign bus.rd_en            = active;
    assign bus.sdram_read_valid = read_valid_q;
    assign bus.lcd_data         = pix_data;
`endif

endmodule
